// File: rtl/cic_decim_mixer.sv
// Decimating CIC filter for one I or Q rail of the receive mixer.
// STAGES pipelined integrators at the input rate, a decimation counter,
// STAGES pipelined comb stages (M=1) at the decimated rate, and a
// round-half-up / positive-saturating output stage.
module cic_decim_mixer #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 16,
  parameter int STAGES = 3,
  parameter int RATE   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_valid,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);

  localparam int CNT_W = $clog2(RATE);
  localparam int ACC_W = IN_W + STAGES * $clog2(RATE);
  // Half an output LSB, used for round-half-up.
  localparam logic [ACC_W-1:0] RND =
    {{OUT_W{1'b0}}, 1'b1, {(ACC_W-OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [ACC_W-1:0]  din_ext;
  logic [CNT_W-1:0]  cnt_reg;
  logic              dec_hit;
  // tok[0] marks E0..E1, tok[k+1] enables comb stage k, tok[STAGES+1] the output.
  logic [STAGES+1:0] tok_reg;
  logic [ACC_W-1:0]  comb_in_reg;
  logic [ACC_W-1:0]  comb_out;
  logic [ACC_W-1:0]  rounded;
  logic              pos_ovf;

  assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
  assign dec_hit = din_valid && (cnt_reg == CNT_W'(RATE - 1));

  genvar gi;

  // Integrator cascade: stage 0 accumulates din, stage k accumulates the
  // registered output of stage k-1. Wraps modulo 2^ACC_W by design.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_integ
      logic [ACC_W-1:0] addend;
      logic [ACC_W-1:0] acc_reg;
      if (gi == 0) begin : g_first
        assign addend = din_ext;
      end else begin : g_rest
        assign addend = g_integ[gi-1].acc_reg;
      end
      // Accumulate only on qualified input samples.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          acc_reg <= '0;
        end else if (din_valid) begin
          acc_reg <= acc_reg + addend;
        end
      end
    end
  endgenerate

  // Decimation counter: advances per valid sample, wraps on the decimating one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (din_valid) begin
      cnt_reg <= dec_hit ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // Decimated valid token shifts one stage per clock through the comb pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_reg <= '0;
    end else begin
      tok_reg <= {tok_reg[STAGES:0], dec_hit};
    end
  end

  // Capture the post-update last integrator one clock after the decimating sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comb_in_reg <= '0;
    end else if (tok_reg[0]) begin
      comb_in_reg <= g_integ[STAGES-1].acc_reg;
    end
  end

  // Comb cascade, one register per stage, each advancing only with its token.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_comb
      logic [ACC_W-1:0] x;
      logic [ACC_W-1:0] y_reg;
      logic [ACC_W-1:0] prev_reg;
      if (gi == 0) begin : g_first
        assign x = comb_in_reg;
      end else begin : g_rest
        assign x = g_comb[gi-1].y_reg;
      end
      // y = x - x_prev at the decimated rate.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          y_reg    <= '0;
          prev_reg <= '0;
        end else if (tok_reg[gi+1]) begin
          y_reg    <= x - prev_reg;
          prev_reg <= x;
        end
      end
    end
  endgenerate

  // Round half up; only a positive value can overflow when adding half an LSB.
  assign comb_out = g_comb[STAGES-1].y_reg;
  assign rounded  = comb_out + RND;
  assign pos_ovf  = ~comb_out[ACC_W-1] & rounded[ACC_W-1];

  // Registered output sample plus single-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= tok_reg[STAGES+1];
      if (tok_reg[STAGES+1]) begin
        dout <= pos_ovf ? OUT_MAX : rounded[ACC_W-1 -: OUT_W];
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_mixer.sv
// Directed bench for cic_decim_mixer: a RATE=64 and a RATE=4 instance share
// stimulus; a sample-level reference CIC (classic integrators fed by a
// STAGES-1 sample input delay) provides bit-exact expected outputs.
module tb_cic_decim_mixer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din_valid = 1'b0;
  logic signed [19:0] din = '0;
  logic signed [15:0] dout64, dout4;
  logic dv64, dv4;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic signed [15:0] got64_q[$], got4_q[$], exp64_q[$], exp4_q[$];
  int cyc64_q[$], e0_q[$];

  longint unsigned m_int[2][3];
  longint unsigned m_prev[2][3];
  longint unsigned m_dly[2][2];
  int m_cnt[2];

  cic_decim_mixer dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout64), .dout_valid(dv64)
  );

  cic_decim_mixer #(.RATE(4)) dut4 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout4), .dout_valid(dv4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output strobe with the number of posedges seen so far.
  always @(negedge clk) begin
    if (dv64) begin
      got64_q.push_back(dout64);
      cyc64_q.push_back(cyc);
    end
    if (dv4) got4_q.push_back(dout4);
  end

  task automatic clear_all();
    got64_q.delete(); got4_q.delete(); exp64_q.delete(); exp4_q.delete();
    cyc64_q.delete(); e0_q.delete();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      for (int k = 0; k < 3; k++) begin m_int[m][k] = 0; m_prev[m][k] = 0; end
      for (int k = 0; k < 2; k++) m_dly[m][k] = 0;
    end
  endtask

  task automatic model_step(input int m, input int x);
    int rate, aw;
    longint unsigned mask, v, y, r, d;
    logic signed [15:0] o;
    rate = (m == 0) ? 64 : 4;
    aw   = (m == 0) ? 38 : 26;
    mask = (64'd1 << aw) - 64'd1;
    v = longint'(x);
    v = v & mask;
    d = m_dly[m][1];
    m_dly[m][1] = m_dly[m][0];
    m_dly[m][0] = v;
    m_int[m][0] = (m_int[m][0] + d) & mask;
    m_int[m][1] = (m_int[m][1] + m_int[m][0]) & mask;
    m_int[m][2] = (m_int[m][2] + m_int[m][1]) & mask;
    m_cnt[m]++;
    if (m_cnt[m] == rate) begin
      m_cnt[m] = 0;
      v = m_int[m][2];
      for (int k = 0; k < 3; k++) begin
        y = (v - m_prev[m][k]) & mask;
        m_prev[m][k] = v;
        v = y;
      end
      r = (v + (64'd1 << (aw - 17))) & mask;
      if (((v >> (aw - 1)) & 64'd1) == 0 && ((r >> (aw - 1)) & 64'd1) == 1)
        o = 16'sh7FFF;
      else
        o = 16'(r >> (aw - 16));
      if (m == 0) exp64_q.push_back(o); else exp4_q.push_back(o);
    end
  endtask

  task automatic send(input int x);
    @(negedge clk);
    din = 20'(x);
    din_valid = 1'b1;
    model_step(0, x);
    model_step(1, x);
    if (m_cnt[0] == 0) e0_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0;
      din = 20'($urandom);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    din_valid = 1'b0;
    #2 reset = 1'b1;
    #1 clear_all();
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    apply_reset();
    n_checks++; if (dout64 !== 16'sd0) $display("FAIL reset_dout: got %0d expected 0", dout64); else n_pass++;
    n_checks++; if (dv64 !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", dv64); else n_pass++;
    // Reset while the output strobe is high must drop it at once.
    repeat (64) send(1000);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (dv64) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL first_pulse: got none expected pulse within 10 cycles"); else n_pass++;
    n_checks++; if (dout64 !== 16'sd10) $display("FAIL first_value: got %0d expected 10", dout64); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (dv64 !== 1'b0) $display("FAIL async_valid: got %0b expected 0", dv64); else n_pass++;
    n_checks++; if (dout64 !== 16'sd0) $display("FAIL async_dout_a: got %0d expected 0", dout64); else n_pass++;
    #1 reset = 1'b0;
    clear_all();
    // Mid-decimation reset with counter at 37 and a nonzero held dout.
    repeat (101) send(1000);
    @(negedge clk);
    din_valid = 1'b0;
    n_checks++; if (dout64 !== 16'sd10) $display("FAIL held_dout: got %0d expected 10", dout64); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (dout64 !== 16'sd0) $display("FAIL async_dout_b: got %0d expected 0", dout64); else n_pass++;
    n_checks++; if (dv64 !== 1'b0) $display("FAIL async_valid_b: got %0b expected 0", dv64); else n_pass++;
    #1 reset = 1'b0;
    clear_all();
    // Fresh count: 63 samples give nothing, the 64th gives one pulse 5 cycles later.
    repeat (63) send(1000);
    idle(10);
    n_checks++; if (got64_q.size() != 0) $display("FAIL early_pulse: got %0d pulses expected 0", got64_q.size()); else n_pass++;
    send(1000);
    idle(8);
    n_checks++; if (got64_q.size() != 1) $display("FAIL fresh_pulse: got %0d pulses expected 1", got64_q.size()); else n_pass++;
    if (got64_q.size() >= 1 && e0_q.size() >= 1) begin
      n_checks++; if (cyc64_q[0] - e0_q[0] != 5) $display("FAIL fresh_latency: got %0d expected 5", cyc64_q[0] - e0_q[0]); else n_pass++;
      n_checks++; if (got64_q[0] !== 16'sd10) $display("FAIL fresh_value: got %0d expected 10", got64_q[0]); else n_pass++;
    end
  endtask

  task automatic test_dc(input int x, input logic signed [15:0] settled);
    apply_reset();
    repeat (640) send(x);
    idle(8);
    n_checks++; if (got64_q.size() != 10) $display("FAIL dc%0d_count64: got %0d expected 10", x, got64_q.size()); else n_pass++;
    n_checks++; if (got4_q.size() != 160) $display("FAIL dc%0d_count4: got %0d expected 160", x, got4_q.size()); else n_pass++;
    for (int i = 0; i < got64_q.size() && i < 10; i++) begin
      n_checks++; if (got64_q[i] !== exp64_q[i]) $display("FAIL dc%0d_model64[%0d]: got %0d expected %0d", x, i, got64_q[i], exp64_q[i]); else n_pass++;
      n_checks++; if (cyc64_q[i] - e0_q[i] != 5) $display("FAIL dc%0d_latency[%0d]: got %0d expected 5", x, i, cyc64_q[i] - e0_q[i]); else n_pass++;
      if (i >= 3) begin
        n_checks++; if (got64_q[i] !== settled) $display("FAIL dc%0d_settled[%0d]: got %0d expected %0d", x, i, got64_q[i], settled); else n_pass++;
      end
    end
    for (int i = 0; i < got4_q.size() && i < 160; i++) begin
      n_checks++; if (got4_q[i] !== exp4_q[i]) $display("FAIL dc%0d_model4[%0d]: got %0d expected %0d", x, i, got4_q[i], exp4_q[i]); else n_pass++;
    end
  endtask

  task automatic test_gapped();
    apply_reset();
    repeat (640) begin
      send(1000);
      idle(2);
    end
    idle(8);
    n_checks++; if (got64_q.size() != 10) $display("FAIL gap_count: got %0d expected 10", got64_q.size()); else n_pass++;
    for (int i = 0; i < got64_q.size() && i < 10; i++) begin
      n_checks++; if (got64_q[i] !== exp64_q[i]) $display("FAIL gap_model[%0d]: got %0d expected %0d", i, got64_q[i], exp64_q[i]); else n_pass++;
      n_checks++; if (cyc64_q[i] - e0_q[i] != 5) $display("FAIL gap_latency[%0d]: got %0d expected 5", i, cyc64_q[i] - e0_q[i]); else n_pass++;
      if (i >= 1) begin
        n_checks++; if (cyc64_q[i] - cyc64_q[i-1] != 192) $display("FAIL gap_spacing[%0d]: got %0d expected 192", i, cyc64_q[i] - cyc64_q[i-1]); else n_pass++;
      end
      if (i >= 3) begin
        n_checks++; if (got64_q[i] !== 16'sd63) $display("FAIL gap_settled[%0d]: got %0d expected 63", i, got64_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    repeat (20000) send(524287);
    repeat (20000) send(-524288);
    idle(8);
    n_checks++; if (got64_q.size() != 625) $display("FAIL wrap_count64: got %0d expected 625", got64_q.size()); else n_pass++;
    n_checks++; if (got4_q.size() != 10000) $display("FAIL wrap_count4: got %0d expected 10000", got4_q.size()); else n_pass++;
    for (int i = 0; i < got64_q.size() && i < exp64_q.size(); i++) begin
      n_checks++; if (got64_q[i] !== exp64_q[i]) $display("FAIL wrap64[%0d]: got %0d expected %0d", i, got64_q[i], exp64_q[i]); else n_pass++;
    end
    for (int i = 0; i < got4_q.size() && i < exp4_q.size(); i++) begin
      n_checks++; if (got4_q[i] !== exp4_q[i]) $display("FAIL wrap4[%0d]: got %0d expected %0d", i, got4_q[i], exp4_q[i]); else n_pass++;
    end
    if (got64_q.size() == 625) begin
      n_checks++; if (got64_q[300] !== 16'sd32767) $display("FAIL wrap64_pos: got %0d expected 32767", got64_q[300]); else n_pass++;
      n_checks++; if (got64_q[624] !== -16'sd32768) $display("FAIL wrap64_neg: got %0d expected -32768", got64_q[624]); else n_pass++;
    end
    if (got4_q.size() == 10000) begin
      n_checks++; if (got4_q[4000] !== 16'sd32767) $display("FAIL wrap4_pos: got %0d expected 32767", got4_q[4000]); else n_pass++;
      n_checks++; if (got4_q[9999] !== -16'sd32768) $display("FAIL wrap4_neg: got %0d expected -32768", got4_q[9999]); else n_pass++;
    end
  endtask

  initial begin
    clear_all();
    reset = 1'b1;
    #12 reset = 1'b0;
    test_reset();
    test_dc(1000, 16'sd63);
    test_dc(-1000, -16'sd62);
    test_dc(-524288, -16'sd32768);
    test_dc(524287, 16'sd32767);
    test_gapped();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cic_decim_mixer.md
Name: cic_decim_mixer

Overview:
- Decimating CIC filter for one I or Q rail of the SDR receive chain.
- Sits directly downstream of the 10x10 signed mixer multiplier and consumes its 20-bit signed product stream.
- Reduces the sample rate by RATE and delivers rounded, saturated OUT_W-bit samples to the baseband/FIFO stage.
- Two instances are used, one for I and one for Q.

Parameters:
- IN_W, 20: input sample width, signed two's complement.
- OUT_W, 16: output sample width, signed.
- STAGES, 3: number of integrator stages and number of comb stages (N); differential delay M=1.
- RATE, 64: decimation ratio, 2..256.
- ACC_W (localparam) = IN_W + STAGES*clog2(RATE): internal register width; 38 at the defaults.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- din, input, IN_W: signed product from the mixer multiplier.
- din_valid, input, 1: din qualifier. The enclosing mixer supplies it as the multiplier ce delayed by 2 cycles, so it is aligned with the multiplier output.
- dout, output, OUT_W: signed decimated sample.
- dout_valid, output, 1: one-cycle strobe marking a new dout.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to 0 immediately, regardless of clk:
  - integrators, comb delay registers, pipeline registers
  - decimation counter, valid pipeline
  - dout and dout_valid
- Reset asserted mid-decimation discards all partial state. The first output after reset follows a fresh RATE-sample count.
- Integrators:
  - STAGES registered accumulators, each ACC_W wide; din is sign-extended to ACC_W.
  - Updated only on cycles with din_valid=1. Stage0 += din; stage k += registered stage k-1 (pipelined cascade).
  - Modular two's-complement wrap is required. No saturation, no overflow flag.
  - din_valid=0 holds every integrator and the counter.
- Decimation counter:
  - Counts 0..RATE-1 and advances on each din_valid.
  - A din_valid arriving while the counter is at RATE-1 is the decimating sample (edge E0). At E0 the counter wraps to 0.
  - At E1, the post-update value of the last integrator is captured into the comb input register.
- Comb chain:
  - STAGES pipelined stages, one register per stage at E2..E(1+STAGES).
  - Stage k: y = x - x_prev; x_prev <- x. Advances only when the decimated valid token is in that stage.
  - Modulo ACC_W arithmetic.
- Output stage (edge E(STAGES+2)):
  - Take the comb result and add 2^(ACC_W-OUT_W-1) (round half up).
  - Output = bits [ACC_W-1 : ACC_W-OUT_W].
  - If the rounding add overflows positive, dout = 2^(OUT_W-1)-1. No negative saturation is needed.
  - dout is registered and holds until the next output. dout_valid is high for exactly one cycle.
- Latency: dout_valid is asserted in the cycle after edge E0+STAGES+2. That is 5 cycles after the decimating din_valid edge at the defaults.
- Throughput: din_valid may be high every cycle. Back-to-back decimated tokens are at least RATE>=2 cycles apart, so the comb pipeline never holds more than one token per stage.
- Gaps in din_valid of any length do not affect the results.
- DC gain is RATE^STAGES; the output scale is 2^-(ACC_W-OUT_W). For a power-of-two RATE, full-scale input maps to full-scale output.
- Settling: after a step input, dout reaches its final value on the (STAGES+1)-th output.

Test Plan:
- Reset behaviour: assert reset asynchronously, between clock edges, mid-run (counter=37) -> dout=0 and dout_valid=0 immediately. After release, the first dout_valid follows exactly 64 din_valid.
- Positive DC: din=1000 constant, din_valid every cycle -> dout_valid every 64 cycles, 5 cycles after each 64th input. dout settles to 63 (62.5 rounded half up) from the 4th output onward.
- Negative DC and minimum full scale:
  - din=-1000 -> dout settles to -62.
  - din=-524288 -> dout settles to -32768.
- Positive full scale saturation: din=524287 -> raw result 32767.9375 rounds to 32768 -> dout saturates to 32767. No wrap to negative.
- Gapped input: same as the din=1000 test, but with din_valid high every 3rd cycle -> identical dout sequence. Exactly 10 dout_valid pulses for 640 valid inputs; pulses spaced 192 cycles apart.
- Integrator wrap: alternate din=+524287 for 20000 samples, then din=-524288 for 20000 samples (integrators overflow) -> dout tracks the expected step values 32767 and -32768 with no glitch beyond the 4-output settling window. Compare sample-by-sample against a bit-exact reference model with RATE=4 and RATE=64.
